// File: rtl/ucode_loader_pkg.sv
// Shared microword geometry and loader state encoding; imported by the control sequencer too.
// Microword layout, MSB to LSB: {dp_ctrl, c_ctrl, next_addr}.
package ucode_loader_pkg;

    localparam int DEF_LOG_MEMSIZE    = 4;
    localparam int DEF_NUM_D_CTRLBITS = 5;
    localparam int DEF_NUM_C_CTRLBITS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int uword_width(input int d_bits, input int c_bits, input int log_mem);
        return d_bits + c_bits + log_mem;
    endfunction

    function automatic int uword_bytes(input int w);
        return (w + 7) / 8;
    endfunction

    // Index width that stays legal when the count collapses to one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_addr_lsb();
        return 0;
    endfunction

    function automatic int c_ctrl_lsb(input int log_mem);
        return log_mem;
    endfunction

    function automatic int dp_ctrl_lsb(input int c_bits, input int log_mem);
        return log_mem + c_bits;
    endfunction

endpackage

// File: rtl/ucode_word_asm.sv
// Little-endian byte-to-microword assembler; word register updates on the edge accepting the last byte.
// No backpressure of its own: it takes whatever byte strobe the loader gives it; pad errors are sticky.
module ucode_word_asm
    import ucode_loader_pkg::*;
#(
    parameter int W   = 11,
    parameter int NB  = uword_bytes(W),
    parameter int BIW = idx_width(NB)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           byte_vld,
    input  logic [BIW-1:0] byte_idx,
    input  logic           byte_last,
    input  logic [7:0]     byte_dat,
    output logic [W-1:0]   word,
    output logic           pad_err
);

    logic [8*NB-1:0] acc_q;
    logic [8*NB-1:0] acc_nxt;
    logic [8*NB-1:0] pad_bits;
    logic            pad_hit;

    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[8*int'(byte_idx) +: 8] = byte_dat;
    end

    // Anything at or above bit W can only come from the final byte.
    assign pad_bits = acc_nxt >> W;
    assign pad_hit  = |pad_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            word    <= '0;
            pad_err <= 1'b0;
        end else if (byte_vld) begin
            acc_q <= acc_nxt;
            if (byte_last) begin
                word <= acc_nxt[W-1:0];
                if (pad_hit) begin
                    pad_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ucode_loader.sv
// Fills the control store from a header+bytes stream, one write strobe per word, stalling the sequencer.
// Write lands the cycle after a word's last byte; in_ready drops during WRITE and DONE, else host may stall freely.
module ucode_loader
    import ucode_loader_pkg::*;
#(
    parameter  int P_LOG_MEMSIZE    = DEF_LOG_MEMSIZE,
    parameter  int P_NUM_D_CTRLBITS = DEF_NUM_D_CTRLBITS,
    parameter  int P_NUM_C_CTRLBITS = DEF_NUM_C_CTRLBITS,
    localparam int W = uword_width(P_NUM_D_CTRLBITS, P_NUM_C_CTRLBITS, P_LOG_MEMSIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [P_LOG_MEMSIZE-1:0] mem_addr,
    output logic [W-1:0]             mem_wdata,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic                     err
);

    localparam int NB  = uword_bytes(W);
    localparam int BIW = idx_width(NB);
    localparam logic [BIW-1:0]         LAST_BYTE = BIW'(NB - 1);
    localparam logic [BIW-1:0]         BYTE_ONE  = BIW'(1);
    localparam logic [P_LOG_MEMSIZE:0] CNT_ONE   = (P_LOG_MEMSIZE + 1)'(1);

    state_t                   state, state_nxt;
    logic [P_LOG_MEMSIZE:0]   word_cnt;
    logic [P_LOG_MEMSIZE:0]   word_idx;
    logic [BIW-1:0]           byte_idx;
    logic [P_LOG_MEMSIZE-1:0] hdr_cnt;
    logic                     accept;
    logic                     data_vld;
    logic                     byte_last;
    logic                     last_word;

    assign accept    = in_valid && in_ready;
    assign data_vld  = accept && (state == DATA);
    assign byte_last = (byte_idx == LAST_BYTE);
    assign hdr_cnt   = in_data[P_LOG_MEMSIZE-1:0];
    // One extra bit so a full-depth load (header 0) terminates at all-ones.
    assign last_word = (word_idx == word_cnt - CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DATA;
            DATA:    if (accept && byte_last) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : DATA;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE, DATA: in_ready  = rst;
            WRITE:      mem_we    = 1'b1;
            DONE:       load_done = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            mem_addr <= '0;
            cpu_hold <= 1'b1;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    word_cnt <= (hdr_cnt == '0) ? {1'b1, {P_LOG_MEMSIZE{1'b0}}} : {1'b0, hdr_cnt};
                    word_idx <= '0;
                    byte_idx <= '0;
                    cpu_hold <= 1'b1;
                end
                DATA: if (accept) begin
                    if (byte_last) begin
                        mem_addr <= word_idx[P_LOG_MEMSIZE-1:0];
                    end else begin
                        byte_idx <= byte_idx + BYTE_ONE;
                    end
                end
                WRITE: if (!last_word) begin
                    word_idx <= word_idx + CNT_ONE;
                    byte_idx <= '0;
                end
                DONE: cpu_hold <= 1'b0;
                default: ;
            endcase
        end
    end

    ucode_word_asm #(
        .W   (W),
        .NB  (NB),
        .BIW (BIW)
    ) u_word_asm (
        .clk       (clk),
        .rst       (rst),
        .byte_vld  (data_vld),
        .byte_idx  (byte_idx),
        .byte_last (byte_last),
        .byte_dat  (in_data),
        .word      (mem_wdata),
        .pad_err   (err)
    );

endmodule

// File: tb/tb_ucode_loader.sv
// Bench for ucode_loader: stream-level reference model checked every cycle, directed scenarios plus random loads.
module tb_ucode_loader;

    localparam int L  = 4;
    localparam int W  = 5 + 2 + L;
    localparam int NB = (W + 7) / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         mem_we;
    logic [L-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         cpu_hold;
    logic         load_done;
    logic         err;

    int errors = 0;
    int checks = 0;
    bit run    = 0;

    int log_addr[$];
    int log_data[$];
    int done_cnt = 0;

    // Reference model: parses the accepted byte stream and predicts the next cycle's outputs.
    bit              e_we, e_done, e_rdy, e_hold, e_err;
    int              e_addr, e_data;
    bit              m_active, last_pending;
    int              m_total, m_widx, m_bcnt;
    logic [8*NB-1:0] m_acc;

    ucode_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            bit n_we, n_done;
            @(negedge clk);
            if (run) begin
                if (!rst) begin
                    check("rst_ready", in_ready, 0);
                    check("rst_we", mem_we, 0);
                    check("rst_addr", mem_addr, 0);
                    check("rst_wdata", mem_wdata, 0);
                    check("rst_hold", cpu_hold, 1);
                    check("rst_done", load_done, 0);
                    check("rst_err", err, 0);
                    e_we = 0; e_done = 0; e_rdy = 1; e_hold = 1; e_err = 0;
                    e_addr = 0; e_data = 0; m_active = 0; last_pending = 0;
                end else begin
                    check("we", mem_we, e_we);
                    check("done", load_done, e_done);
                    check("ready", in_ready, e_rdy);
                    check("hold", cpu_hold, e_hold);
                    check("err", err, e_err);
                    check("addr", mem_addr, e_addr);
                    check("wdata", mem_wdata, e_data);
                    if (mem_we) begin
                        log_addr.push_back(int'(mem_addr));
                        log_data.push_back(int'(mem_wdata));
                    end
                    if (load_done) done_cnt++;
                    n_we   = 0;
                    n_done = e_we && last_pending;
                    if (n_done) last_pending = 0;
                    if (e_done) e_hold = 0;
                    if (in_valid && e_rdy) begin
                        if (!m_active) begin
                            m_active = 1;
                            m_total  = (in_data % 16 == 0) ? 16 : int'(in_data % 16);
                            m_widx   = 0;
                            m_bcnt   = 0;
                            m_acc    = '0;
                            e_hold   = 1;
                        end else begin
                            m_acc[8*m_bcnt +: 8] = in_data;
                            m_bcnt++;
                            if (m_bcnt == NB) begin
                                n_we   = 1;
                                e_addr = m_widx;
                                e_data = int'(m_acc % (1 << W));
                                if ((m_acc >> W) != 0) e_err = 1;
                                m_widx++;
                                m_bcnt = 0;
                                if (m_widx == m_total) begin
                                    m_active     = 0;
                                    last_pending = 1;
                                end
                            end
                        end
                    end
                    e_we   = n_we;
                    e_done = n_done;
                    e_rdy  = !(n_we || n_done);
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input int gmin, input int gmax);
        int gap;
        int guard;
        bit acc;
        gap   = int'($urandom_range(gmax, gmin));
        guard = 0;
        acc   = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && guard < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        check("push_accept", acc, 1);
    endtask

    task automatic pulse_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    initial begin
        int base, dbase, n, abort_at, gmax;
        logic [7:0] hdr, b;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        #2 rst = 1'b0;
        run = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("reset_ready", in_ready, 0);
        check("reset_hold", cpu_hold, 1);
        check("reset_we", mem_we, 0);
        check("reset_wdata", mem_wdata, 0);
        rst = 1'b1;
        idle(2);

        // Two-word load
        base = log_addr.size(); dbase = done_cnt;
        check("t1_hold_before", cpu_hold, 1);
        push(8'h02, 0, 0); push(8'h34, 0, 0); push(8'h05, 0, 0);
        push(8'hFF, 0, 0); push(8'h07, 0, 0);
        idle(4);
        check("t1_writes", log_addr.size() - base, 2);
        check("t1_addr0", log_addr[base], 0);
        check("t1_data0", log_data[base], 32'h534);
        check("t1_addr1", log_addr[base+1], 1);
        check("t1_data1", log_data[base+1], 32'h7FF);
        check("t1_dones", done_cnt - dbase, 1);
        check("t1_hold_after", cpu_hold, 0);
        check("t1_err", err, 0);

        // Header 0 means full depth
        base = log_addr.size(); dbase = done_cnt;
        push(8'h00, 0, 0);
        for (int i = 0; i < 32; i++) push(8'($urandom) & ((i % 2 == 1) ? 8'h07 : 8'hFF), 0, 0);
        idle(4);
        check("t2_writes", log_addr.size() - base, 16);
        for (int i = 0; i < 16; i++) check("t2_addr", log_addr[base+i], i);
        check("t2_dones", done_cnt - dbase, 1);

        // Pad bits set -> sticky err
        base = log_addr.size();
        push(8'h01, 0, 0); push(8'h00, 0, 0); push(8'h08, 0, 0);
        idle(4);
        check("t3_data", log_data[base], 0);
        check("t3_err", err, 1);
        push(8'h01, 0, 0); push(8'h11, 0, 0); push(8'h01, 0, 0);
        idle(4);
        check("t3_err_sticky", err, 1);

        // Host valid toggling every other cycle
        base = log_addr.size(); dbase = done_cnt;
        push(8'h01, 1, 1); push(8'hAA, 1, 1); push(8'h02, 1, 1);
        idle(4);
        check("t4_writes", log_addr.size() - base, 1);
        check("t4_data", log_data[base], 32'h2AA);
        check("t4_dones", done_cnt - dbase, 1);

        // Reset after first byte of word 1 of a 3-word load
        base = log_addr.size();
        push(8'h03, 0, 0); push(8'h12, 0, 0); push(8'h03, 0, 0); push(8'h56, 0, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_we_in_rst", mem_we, 0);
        check("t5_hold_in_rst", cpu_hold, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_ready_idle", in_ready, 1);
        check("t5_writes", log_addr.size() - base, 1);
        base = log_addr.size();
        push(8'h01, 0, 0); push(8'h9C, 0, 0); push(8'h02, 0, 0);
        idle(4);
        check("t5_restart_addr", log_addr[base], 0);
        check("t5_restart_data", log_data[base], 32'h29C);

        // Back-to-back loads with valid held high
        base = log_addr.size(); dbase = done_cnt;
        push(8'h01, 0, 0); push(8'h21, 0, 0); push(8'h04, 0, 0);
        push(8'h02, 0, 0);
        check("t6_hold_reassert", cpu_hold, 1);
        push(8'h43, 0, 0); push(8'h06, 0, 0); push(8'h65, 0, 0); push(8'h01, 0, 0);
        idle(4);
        check("t6_writes", log_addr.size() - base, 3);
        check("t6_addr0", log_addr[base], 0);
        check("t6_addr1", log_addr[base+1], 0);
        check("t6_addr2", log_addr[base+2], 1);
        check("t6_data2", log_data[base+2], 32'h165);
        check("t6_dones", done_cnt - dbase, 2);

        // Random loads, occasional mid-load reset
        for (int it = 0; it < 25; it++) begin
            hdr      = 8'($urandom);
            n        = (hdr[3:0] == 4'h0) ? 16 : int'(hdr[3:0]);
            gmax     = int'($urandom_range(2, 0));
            abort_at = ($urandom_range(5, 0) == 0) ? int'($urandom_range(n*NB - 1, 0)) : -1;
            push(hdr, 0, gmax);
            for (int k = 0; k < n*NB; k++) begin
                if (k == abort_at) begin
                    pulse_reset();
                    break;
                end
                b = 8'($urandom);
                if ((k % NB == NB - 1) && ($urandom_range(3, 0) != 0)) b = b & 8'h07;
                push(b, 0, gmax);
            end
            idle(int'($urandom_range(3, 0)));
        end
        idle(4);

        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
